// File: rtl/crc_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : crc_frame_tx
// Brief    : Buffers a byte payload, then serialises preamble, length,
//            payload and CRC onto one line at CLK_DIV clocks per bit.
// Revision : 1.0 - initial release
// ============================================================================
module crc_frame_tx #(
    parameter int unsigned       PAYLOAD_BYTES = 16,
    parameter int unsigned       CRC_W         = 8,
    parameter logic [CRC_W-1:0]  CRC_POLY      = 8'h07,
    parameter logic [CRC_W-1:0]  CRC_INIT      = '0,
    parameter int unsigned       CLK_DIV       = 16,
    parameter int unsigned       PRE_W         = 8,
    parameter logic [PRE_W-1:0]  PREAMBLE      = 8'hA5,
    localparam int unsigned      CNT_W         = $clog2(PAYLOAD_BYTES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    input  logic             tx_start,
    input  logic             test_mode,
    output logic             tx_line,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] byte_count
);

    localparam int unsigned c_SH_W   = (PRE_W > CRC_W) ? ((PRE_W > 8) ? PRE_W : 8)
                                                       : ((CRC_W > 8) ? CRC_W : 8);
    localparam int unsigned c_IDX_W  = $clog2(c_SH_W);
    localparam int unsigned c_DIV_W  = $clog2(CLK_DIV);
    localparam int unsigned c_BIDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_PRE   = 3'd2,
        S_LEN   = 3'd3,
        S_DATA  = 3'd4,
        S_CRC   = 3'd5,
        S_STOP  = 3'd6
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic [c_DIV_W-1:0]   r_div;
    logic [c_IDX_W-1:0]   r_bit_idx;
    logic [CNT_W-1:0]     r_byte_idx;
    logic [CNT_W-1:0]     r_byte_count;
    logic [c_SH_W-1:0]    r_shift;
    logic [CRC_W-1:0]     r_crc;
    logic                 r_test;
    logic [7:0]           r_buf [PAYLOAD_BYTES];

    logic                 w_accept;
    logic                 w_buf_full;
    logic                 w_bit_end;
    logic                 w_last_bit;
    logic                 w_last_byte;
    logic                 w_start;
    logic                 w_fb;
    logic [CRC_W-1:0]     w_crc_step;
    logic [CRC_W-1:0]     w_crc_tx;
    logic [CNT_W-1:0]     w_rd_idx;
    logic [7:0]           w_rd_byte;
    logic [7:0]           w_len;

    assign w_accept    = (r_state == S_IDLE) && in_valid;
    assign w_buf_full  = (r_byte_count == CNT_W'(PAYLOAD_BYTES - 1));
    assign w_bit_end   = (r_div == c_DIV_W'(CLK_DIV - 1));
    assign w_last_byte = (r_byte_idx == r_byte_count - 1'b1);
    assign w_start     = (r_state == S_ARMED) && tx_start;
    assign w_len       = 8'(r_byte_count);

    // tx_line is the MSB of r_shift, so the CRC folds in each payload bit as it leaves
    assign w_fb       = r_crc[CRC_W-1] ^ r_shift[c_SH_W-1];
    assign w_crc_step = {r_crc[CRC_W-2:0], 1'b0} ^ (w_fb ? CRC_POLY : '0);
    assign w_crc_tx   = w_crc_step ^ CRC_W'(r_test);

    // LEN loads byte 0; DATA preloads the byte that follows the one on the line
    assign w_rd_idx  = (r_state == S_DATA) ? r_byte_idx + 1'b1 : '0;
    assign w_rd_byte = r_buf[c_BIDX_W'(w_rd_idx)];

    assign in_ready   = (r_state == S_IDLE);
    assign busy       = r_state inside {S_PRE, S_LEN, S_DATA, S_CRC, S_STOP};
    assign done       = (r_state == S_STOP) && w_bit_end;
    assign tx_line    = r_shift[c_SH_W-1];
    assign byte_count = r_byte_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_last_bit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (in_last || w_buf_full)) begin
                    w_state_nx = S_ARMED;
                end
            end
            S_ARMED: begin
                if (tx_start) begin
                    w_state_nx = S_PRE;
                end
            end
            S_PRE: begin
                w_last_bit = (r_bit_idx == c_IDX_W'(PRE_W - 1));
                if (w_bit_end && w_last_bit) begin
                    w_state_nx = S_LEN;
                end
            end
            S_LEN: begin
                w_last_bit = (r_bit_idx == c_IDX_W'(7));
                if (w_bit_end && w_last_bit) begin
                    w_state_nx = S_DATA;
                end
            end
            S_DATA: begin
                w_last_bit = (r_bit_idx == c_IDX_W'(7));
                if (w_bit_end && w_last_bit && w_last_byte) begin
                    w_state_nx = S_CRC;
                end
            end
            S_CRC: begin
                w_last_bit = (r_bit_idx == c_IDX_W'(CRC_W - 1));
                if (w_bit_end && w_last_bit) begin
                    w_state_nx = S_STOP;
                end
            end
            S_STOP: begin
                w_last_bit = 1'b1;
                if (w_bit_end) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[c_BIDX_W'(r_byte_count)] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div        <= '0;
            r_bit_idx    <= '0;
            r_byte_idx   <= '0;
            r_byte_count <= '0;
            r_shift      <= '1;
            r_crc        <= CRC_INIT;
            r_test       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_byte_count <= r_byte_count + 1'b1;
            end
            if (w_start) begin
                r_test     <= test_mode;
                r_crc      <= CRC_INIT;
                r_div      <= '0;
                r_bit_idx  <= '0;
                r_byte_idx <= '0;
                r_shift    <= c_SH_W'(PREAMBLE) << (c_SH_W - PRE_W);
            end else if (busy) begin
                if (!w_bit_end) begin
                    r_div <= r_div + 1'b1;
                end else begin
                    r_div     <= '0;
                    r_bit_idx <= w_last_bit ? '0 : r_bit_idx + 1'b1;
                    r_shift   <= {r_shift[c_SH_W-2:0], 1'b1};
                    case (r_state)
                        S_PRE: begin
                            if (w_last_bit) begin
                                r_shift <= c_SH_W'(w_len) << (c_SH_W - 8);
                            end
                        end
                        S_LEN: begin
                            if (w_last_bit) begin
                                r_shift <= c_SH_W'(w_rd_byte) << (c_SH_W - 8);
                            end
                        end
                        S_DATA: begin
                            r_crc <= w_crc_step;
                            if (w_last_bit) begin
                                if (w_last_byte) begin
                                    r_shift <= c_SH_W'(w_crc_tx) << (c_SH_W - CRC_W);
                                end else begin
                                    r_byte_idx <= r_byte_idx + 1'b1;
                                    r_shift    <= c_SH_W'(w_rd_byte) << (c_SH_W - 8);
                                end
                            end
                        end
                        S_CRC: begin
                            if (w_last_bit) begin
                                r_shift <= '1;
                            end
                        end
                        S_STOP: begin
                            r_shift      <= '1;
                            r_byte_count <= '0;
                        end
                        default: begin
                            r_shift <= '1;
                        end
                    endcase
                end
            end
        end
    end

endmodule
`default_nettype wire
